// File: rtl/can_bit_sync_ctrl_if.sv
// can_bit_sync_ctrl_if: config, rx line and bit-timing outputs of the CAN bit synchroniser
interface can_bit_sync_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             enable;
    logic             rx;
    logic [CNT_W-1:0] cfg_tq_per_bit;
    logic [CNT_W-1:0] cfg_sample_pt;
    logic [3:0]       cfg_sjw;
    logic [1:0]       state;
    logic             bit_start;
    logic             sample_strobe;
    logic             rx_bit;
    logic             lock;
    logic             bus_idle;
    logic             cfg_err;

    modport master (
        output enable, rx, cfg_tq_per_bit, cfg_sample_pt, cfg_sjw,
        input  state, bit_start, sample_strobe, rx_bit, lock, bus_idle, cfg_err
    );

    modport slave (
        input  enable, rx, cfg_tq_per_bit, cfg_sample_pt, cfg_sjw,
        output state, bit_start, sample_strobe, rx_bit, lock, bus_idle, cfg_err
    );
endinterface

// File: rtl/can_bit_sync_ctrl.sv
// can_bit_sync_ctrl: CAN bit-timing sequencer with hard sync, SJW-limited resync and idle detection
module can_bit_sync_ctrl #(
    parameter int CNT_W     = 8,
    parameter int IDLE_BITS = 11
) (
    input logic                sampleclk,
    input logic                rst_n,
    can_bit_sync_ctrl_if.slave bus
);
    typedef enum logic [1:0] {OFF = 2'b00, WAIT = 2'b01, RUN = 2'b10} state_t;
    localparam int RW = $clog2(IDLE_BITS + 1);

    state_t           st, st_n;
    logic [CNT_W-1:0] cnt, cnt_n, n, s, sjw, step, e, lim, early_cnt, corr;
    logic [RW-1:0]    rec, rec_n;
    logic             rx_q, rs, rs_n, bit_start_q, bs_n, strobe_q, cap;
    logic             rx_bit_q, rxb_n, lock_q, lock_n, cfg_err_q;
    logic             valid, fall, run, resync;

    assign n     = bus.cfg_tq_per_bit;
    assign s     = bus.cfg_sample_pt;
    assign sjw   = CNT_W'(bus.cfg_sjw);
    assign valid = n >= CNT_W'(4) && s >= CNT_W'(2) && s <= n - CNT_W'(2) && sjw != '0 && sjw <= s;
    assign fall  = rx_q & ~bus.rx;

    // Next state: disable or bad config always wins, otherwise hard sync and idle return
    always_comb begin
        st_n = st;
        if (!bus.enable || !valid) st_n = OFF;
        else if (st == OFF) st_n = WAIT;
        else if (st == WAIT && fall) st_n = RUN;
        else if (st == RUN && rec == RW'(IDLE_BITS)) st_n = WAIT;
    end

    // Datapath: tq counter with one resync per bit, sampling and recessive run length
    always_comb begin
        run       = st == RUN && st_n == RUN;
        step      = cnt >= n - CNT_W'(1) ? '0 : cnt + CNT_W'(1);
        e         = cnt > s ? n - cnt : cnt;
        lim       = e < sjw ? e : sjw;
        early_cnt = cnt + CNT_W'(1) + sjw;
        corr      = cnt == '0 ? step :
                    cnt <= s ? cnt + CNT_W'(1) - lim :
                    (e <= sjw || early_cnt == n) ? '0 : early_cnt;
        resync    = run && fall && (!rs || cnt == '0);
        cap       = run && cnt == s;
        cnt_n     = !run ? '0 : resync ? corr : step;
        rs_n      = run && (resync || (rs && cnt != '0));
        rec_n     = !run ? '0 : cap ? (bus.rx ? rec + RW'(1) : '0) : rec;
        lock_n    = st_n != RUN ? 1'b0 : !run ? 1'b1 : resync ? e <= sjw : lock_q;
        rxb_n     = cap ? bus.rx : rx_bit_q;
        bs_n      = st_n == RUN && cnt_n == '0;
    end

    // State and output registers; rx_q resets recessive so reset release cannot fake an edge
    always_ff @(posedge sampleclk) begin
        if (!rst_n) begin
            st          <= OFF;
            cnt         <= '0;
            rec         <= '0;
            rs          <= 1'b0;
            rx_q        <= 1'b1;
            bit_start_q <= 1'b0;
            strobe_q    <= 1'b0;
            rx_bit_q    <= 1'b1;
            lock_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            st          <= st_n;
            cnt         <= cnt_n;
            rec         <= rec_n;
            rs          <= rs_n;
            rx_q        <= bus.rx;
            bit_start_q <= bs_n;
            strobe_q    <= cap;
            rx_bit_q    <= rxb_n;
            lock_q      <= lock_n;
            cfg_err_q   <= !valid;
        end
    end

    assign bus.state         = st;
    assign bus.bit_start     = bit_start_q;
    assign bus.sample_strobe = strobe_q;
    assign bus.rx_bit        = rx_bit_q;
    assign bus.lock          = lock_q;
    assign bus.bus_idle      = st == WAIT;
    assign bus.cfg_err       = cfg_err_q;
endmodule

// File: tb/tb_can_bit_sync_ctrl.sv
// tb_can_bit_sync_ctrl: directed scoreboard bench for the CAN bit synchroniser
module tb_can_bit_sync_ctrl;
    typedef struct {
        int   cyc;
        logic bs, ss, rxb, lk;
    } ev_t;
    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic       idle, err, lk, rxb;
    } st_t;

    logic sampleclk = 1'b0;
    logic rst_n     = 1'b0;
    int   cyc       = 0;
    int   total     = 0;
    int   bad       = 0;
    ev_t  evq[$];
    st_t  stq[$];
    ev_t  ev;
    st_t  sx;

    can_bit_sync_ctrl_if bus ();
    can_bit_sync_ctrl dut (.sampleclk(sampleclk), .rst_n(rst_n), .bus(bus));

    always #5 sampleclk = ~sampleclk;
    always @(posedge sampleclk) cyc <= cyc + 1;

    task automatic tick(input int k);
        repeat (k) @(posedge sampleclk);
        #1;
    endtask

    task automatic exp_ev(input int c, input logic bs, input logic ss, input logic rxb, input logic lk);
        evq.push_back('{c, bs, ss, rxb, lk});
    endtask

    task automatic exp_st(input int c, input logic [1:0] st, input logic idle, input logic err,
                          input logic lk, input logic rxb);
        stq.push_back('{c, st, idle, err, lk, rxb});
    endtask

    // One undisturbed bit starting at the current cycle (cnt==0); rx is set to v at tq 0
    task automatic send_bit(input logic v, input logic prev, input logic lk_bs, input logic lk_ss);
        exp_ev(cyc, 1'b1, 1'b0, prev, lk_bs);
        exp_ev(cyc + 8, 1'b0, 1'b1, v, lk_ss);
        bus.rx = v;
        tick(10);
    endtask

    // Monitor: strobes are matched against the event queue, state checkpoints by cycle
    always @(negedge sampleclk) begin
        if (bus.bit_start === 1'b1 || bus.sample_strobe === 1'b1) begin
            total++;
            if (evq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe cyc=%0d bs=%b ss=%b", cyc, bus.bit_start, bus.sample_strobe);
            end else begin
                ev = evq.pop_front();
                if (ev.cyc != cyc || bus.bit_start !== ev.bs || bus.sample_strobe !== ev.ss ||
                    bus.rx_bit !== ev.rxb || bus.lock !== ev.lk) begin
                    bad++;
                    $display("FAIL strobe got cyc=%0d bs=%b ss=%b rx_bit=%b lock=%b want cyc=%0d bs=%b ss=%b rx_bit=%b lock=%b",
                             cyc, bus.bit_start, bus.sample_strobe, bus.rx_bit, bus.lock,
                             ev.cyc, ev.bs, ev.ss, ev.rxb, ev.lk);
                end
            end
        end else if (evq.size() > 0 && evq[0].cyc <= cyc) begin
            total++;
            bad++;
            ev = evq.pop_front();
            $display("FAIL missing_strobe at cyc=%0d want bs=%b ss=%b got none", ev.cyc, ev.bs, ev.ss);
        end
        while (stq.size() > 0 && stq[0].cyc <= cyc) begin
            sx = stq.pop_front();
            total++;
            if (sx.cyc != cyc || bus.state !== sx.st || bus.bus_idle !== sx.idle || bus.cfg_err !== sx.err ||
                bus.lock !== sx.lk || bus.rx_bit !== sx.rxb ||
                (sx.st != 2'b10 && (bus.bit_start !== 1'b0 || bus.sample_strobe !== 1'b0))) begin
                bad++;
                $display("FAIL status@%0d got st=%b idle=%b err=%b lock=%b rx_bit=%b bs=%b ss=%b want st=%b idle=%b err=%b lock=%b rx_bit=%b",
                         sx.cyc, bus.state, bus.bus_idle, bus.cfg_err, bus.lock, bus.rx_bit,
                         bus.bit_start, bus.sample_strobe, sx.st, sx.idle, sx.err, sx.lk, sx.rxb);
            end
        end
    end

    initial begin
        bus.enable         = 1'b1;
        bus.rx             = 1'b1;
        bus.cfg_tq_per_bit = 8'd10;
        bus.cfg_sample_pt  = 8'd7;
        bus.cfg_sjw        = 4'd2;
        rst_n              = 1'b0;
        tick(2);
        exp_st(cyc, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        exp_st(cyc + 1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(5);
        // hard sync
        bus.rx = 1'b0;
        exp_ev(cyc + 1, 1'b1, 1'b0, 1'b1, 1'b1);
        exp_st(cyc + 1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(1);
        exp_ev(cyc + 8, 1'b0, 1'b1, 1'b0, 1'b1);
        tick(10);
        send_bit(1'b1, 1'b0, 1'b1, 1'b1);
        send_bit(1'b0, 1'b1, 1'b1, 1'b1);
        send_bit(1'b1, 1'b0, 1'b1, 1'b1);
        // late edge p=2: absorbed fully, bit stretched by 2 tq
        exp_ev(cyc, 1'b1, 1'b0, 1'b1, 1'b1);
        tick(2);
        bus.rx = 1'b0;
        exp_ev(cyc + 8, 1'b0, 1'b1, 1'b0, 1'b1);
        tick(10);
        send_bit(1'b1, 1'b0, 1'b1, 1'b1);
        // late edge p=5: only sjw absorbed, lock drops
        exp_ev(cyc, 1'b1, 1'b0, 1'b1, 1'b1);
        tick(5);
        bus.rx = 1'b0;
        exp_st(cyc + 1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_ev(cyc + 5, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(7);
        send_bit(1'b1, 1'b0, 1'b0, 1'b0);
        // early edge p=9, e=1: new bit next cycle, lock regained
        exp_ev(cyc, 1'b1, 1'b0, 1'b1, 1'b0);
        exp_ev(cyc + 8, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(9);
        bus.rx = 1'b0;
        exp_ev(cyc + 1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick(1);
        exp_ev(cyc + 8, 1'b0, 1'b1, 1'b0, 1'b1);
        tick(10);
        // early edge p=8 with sjw=1, e=2: 8+1+1 wraps to 0, lock drops
        bus.cfg_sjw = 4'd1;
        send_bit(1'b1, 1'b0, 1'b1, 1'b1);
        exp_ev(cyc, 1'b1, 1'b0, 1'b1, 1'b1);
        exp_ev(cyc + 8, 1'b0, 1'b1, 1'b1, 1'b1);
        tick(8);
        bus.rx = 1'b0;
        exp_ev(cyc + 1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(1);
        exp_ev(cyc + 8, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(10);
        // idle: exactly 11 recessive samples then WAIT
        bus.cfg_sjw = 4'd2;
        for (int k = 0; k < 10; k++) send_bit(1'b1, k == 0 ? 1'b0 : 1'b1, 1'b0, 1'b0);
        exp_ev(cyc, 1'b1, 1'b0, 1'b1, 1'b0);
        exp_ev(cyc + 8, 1'b0, 1'b1, 1'b1, 1'b0);
        exp_st(cyc + 9, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(14);
        // re-hard-sync from WAIT
        bus.rx = 1'b0;
        exp_ev(cyc + 1, 1'b1, 1'b0, 1'b1, 1'b1);
        exp_st(cyc + 1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(6);
        // invalid config S=9 with N=10 forces OFF before the sample point
        bus.cfg_sample_pt = 8'd9;
        exp_st(cyc + 1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
        tick(3);
        bus.cfg_sample_pt = 8'd7;
        exp_st(cyc + 1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(2);
        bus.rx = 1'b1;
        tick(2);
        bus.rx = 1'b0;
        exp_ev(cyc + 1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick(1);
        exp_ev(cyc + 8, 1'b0, 1'b1, 1'b0, 1'b1);
        tick(10);
        // disable exactly at the sample point: OFF wins, no strobe, rx_bit held
        exp_ev(cyc, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(7);
        bus.enable = 1'b0;
        exp_st(cyc + 1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(15);
        // reset mid-RUN
        bus.enable = 1'b1;
        bus.rx     = 1'b1;
        tick(2);
        bus.rx = 1'b0;
        exp_ev(cyc + 1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(1);
        exp_ev(cyc + 8, 1'b0, 1'b1, 1'b0, 1'b1);
        tick(10);
        exp_ev(cyc, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(2);
        rst_n = 1'b0;
        exp_st(cyc + 1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(1);
        rst_n = 1'b1;
        exp_st(cyc + 1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(12);
        total++;
        if (evq.size() != 0 || stq.size() != 0) begin
            bad++;
            $display("FAIL leftover_expectations got ev=%0d st=%0d want 0", evq.size(), stq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
